pipe_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard for the in-order pipelined core; replaces the per-stage
//  ad-hoc rx compare/stall logic. Tracks destination registers of STAGES in-flight slots

---
 rtl/pipe_scoreboard.sv | 128 ++++++++++++
 tb/tb_pipe_scoreboard.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: RAW hazard scoreboard for the in-order pipeline.
// Tracks destination registers of STAGES in-flight slots from issue to
// writeback, stalls decode on RAW hazards, kills wrong-path slots on
// FLUSH, and counts stall cycles (saturating).
// Optional feature macro: PIPE_SB_FWD_EN (forward from writeback slot).
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   ISSUE/DSTWE/DSTREG    decode instruction and its destination
//   ISLOAD                result only available at writeback
//   SRCnUSE/SRCn          source operands read by the instruction
//   FLUSH                 kill wrong-path work
//   STALL, FWD1, FWD2     hazard outputs (combinational)
//   BUSY                  per-register pending-write bits
//   RETIRE_VLD/REG        writeback slot contents
//   STALLCNT              saturating stall-cycle counter
module pipe_scoreboard #(
   parameter int REGNOBITS  = 5,
   parameter int NUMREGS    = 32,
   parameter int STAGES     = 2,
   parameter int KILLSTAGES = 2,
   parameter int CNTBITS    = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ISSUE,
   input  logic                 DSTWE,
   input  logic [REGNOBITS-1:0] DSTREG,
   input  logic                 ISLOAD,
   input  logic                 SRC1USE,
   input  logic [REGNOBITS-1:0] SRC1,
   input  logic                 SRC2USE,
   input  logic [REGNOBITS-1:0] SRC2,
   input  logic                 FLUSH,
   output logic                 STALL,
   output logic                 FWD1,
   output logic                 FWD2,
   output logic [NUMREGS-1:0]   BUSY,
   output logic                 RETIRE_VLD,
   output logic [REGNOBITS-1:0] RETIRE_REG,
   output logic [CNTBITS-1:0]   STALLCNT
);

`ifdef PIPE_SB_FWD_EN
   localparam logic FwdEn = 1'b1;
`else
   localparam logic FwdEn = 1'b0;
`endif

   localparam int WB = STAGES - 1;

   logic [STAGES-1:0]    vld_q, vld_d;
   logic [STAGES-1:0]    ld_q, ld_d;
   logic [REGNOBITS-1:0] reg_q [STAGES];
   logic [REGNOBITS-1:0] reg_d [STAGES];
   logic [CNTBITS-1:0]   cnt_q, cnt_d;

   logic y1, y2, w1, w2, c1, c2, h1, h2;
   logic stall_c, accept;

   // y*: match in a slot younger than writeback; w*: match in writeback.
   // c*: forwarding candidate (only a non-load writeback match).
   always_comb begin
      y1 = 1'b0;
      y2 = 1'b0;
      for (int k = 0; k < WB; k++) begin
         if (vld_q[k] && reg_q[k] == SRC1) y1 = 1'b1;
         if (vld_q[k] && reg_q[k] == SRC2) y2 = 1'b1;
      end
      w1 = vld_q[WB] && (reg_q[WB] == SRC1);
      w2 = vld_q[WB] && (reg_q[WB] == SRC2);
      c1 = FwdEn && SRC1USE && !y1 && w1 && !ld_q[WB];
      c2 = FwdEn && SRC2USE && !y2 && w2 && !ld_q[WB];
      h1 = SRC1USE && (y1 || w1) && !c1;
      h2 = SRC2USE && (y2 || w2) && !c2;
      stall_c = ISSUE && !FLUSH && (h1 || h2);
   end

   assign STALL = stall_c;
   assign FWD1  = ISSUE && !FLUSH && !stall_c && c1;
   assign FWD2  = ISSUE && !FLUSH && !stall_c && c2;

   always_comb begin
      accept    = ISSUE && !stall_c && !FLUSH;
      vld_d     = '0;
      ld_d      = '0;
      reg_d[0]  = accept ? DSTREG : '0;
      vld_d[0]  = accept && DSTWE;
      ld_d[0]   = accept && ISLOAD;
      // Pre-shift slots 0..KILLSTAGES-1 die on FLUSH.
      for (int k = 1; k < STAGES; k++) begin
         vld_d[k] = vld_q[k-1] && !(FLUSH && (k <= KILLSTAGES));
         ld_d[k]  = ld_q[k-1];
         reg_d[k] = reg_q[k-1];
      end
      cnt_d = cnt_q;
      if (stall_c && (cnt_q != {CNTBITS{1'b1}}))
         cnt_d = cnt_q + CNTBITS'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_q <= '0;
         ld_q  <= '0;
         cnt_q <= '0;
         for (int k = 0; k < STAGES; k++)
            reg_q[k] <= '0;
      end else begin
         vld_q <= vld_d;
         ld_q  <= ld_d;
         cnt_q <= cnt_d;
         for (int k = 0; k < STAGES; k++)
            reg_q[k] <= reg_d[k];
      end
   end

   always_comb begin
      BUSY = '0;
      for (int r = 0; r < NUMREGS; r++)
         for (int k = 0; k < STAGES; k++)
            if (vld_q[k] && reg_q[k] == REGNOBITS'(r))
               BUSY[r] = 1'b1;
   end

   assign RETIRE_VLD = vld_q[WB];
   assign RETIRE_REG = vld_q[WB] ? reg_q[WB] : '0;
   assign STALLCNT   = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: self-checking bench for pipe_scoreboard.
// Retire events are scoreboarded through a queue of expected retires.
module tb_pipe_scoreboard;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ISSUE = 1'b0, DSTWE = 1'b0, ISLOAD = 1'b0;
   logic [4:0]  DSTREG = '0, SRC1 = '0, SRC2 = '0;
   logic        SRC1USE = 1'b0, SRC2USE = 1'b0, FLUSH = 1'b0;

   logic        STALL, FWD1, FWD2, RETIRE_VLD;
   logic [31:0] BUSY;
   logic [4:0]  RETIRE_REG;
   logic [15:0] STALLCNT;

   logic        STALL2, FWD1_2, FWD2_2, RETIRE_VLD2;
   logic [31:0] BUSY2;
   logic [4:0]  RETIRE_REG2;
   logic [1:0]  STALLCNT2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         c;
      logic [4:0] r;
   } ret_t;
   ret_t exp_q[$];
   ret_t e;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   pipe_scoreboard dut (
      .CLK(CLK), .RESET(RESET), .ISSUE(ISSUE), .DSTWE(DSTWE),
      .DSTREG(DSTREG), .ISLOAD(ISLOAD), .SRC1USE(SRC1USE),
      .SRC1(SRC1), .SRC2USE(SRC2USE), .SRC2(SRC2), .FLUSH(FLUSH),
      .STALL(STALL), .FWD1(FWD1), .FWD2(FWD2), .BUSY(BUSY),
      .RETIRE_VLD(RETIRE_VLD), .RETIRE_REG(RETIRE_REG),
      .STALLCNT(STALLCNT)
   );

   pipe_scoreboard #(.STAGES(8), .KILLSTAGES(2), .CNTBITS(2)) dut2 (
      .CLK(CLK), .RESET(RESET), .ISSUE(ISSUE), .DSTWE(DSTWE),
      .DSTREG(DSTREG), .ISLOAD(ISLOAD), .SRC1USE(SRC1USE),
      .SRC1(SRC1), .SRC2USE(SRC2USE), .SRC2(SRC2), .FLUSH(FLUSH),
      .STALL(STALL2), .FWD1(FWD1_2), .FWD2(FWD2_2), .BUSY(BUSY2),
      .RETIRE_VLD(RETIRE_VLD2), .RETIRE_REG(RETIRE_REG2),
      .STALLCNT(STALLCNT2)
   );

   // Retire monitor: every retire must match the head of the queue.
   always @(negedge CLK) begin
      if (!RESET && RETIRE_VLD) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL retire_unexpected: got r%0d cycle %0d, required none",
                     RETIRE_REG, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.c != cyc || e.r !== RETIRE_REG) begin
               errors++;
               $display("FAIL retire: got r%0d cycle %0d, required r%0d cycle %0d",
                        RETIRE_REG, cyc, e.r, e.c);
            end
         end
      end else if (!RESET && exp_q.size() > 0 && exp_q[0].c <= cyc) begin
         checks++;
         errors++;
         $display("FAIL retire_missing: none at cycle %0d, required r%0d",
                  cyc, exp_q[0].r);
         void'(exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic iss, input logic we, input logic [4:0] dr,
                        input logic ld, input logic u1, input logic [4:0] s1,
                        input logic u2, input logic [4:0] s2, input logic fl);
      ISSUE = iss; DSTWE = we; DSTREG = dr; ISLOAD = ld;
      SRC1USE = u1; SRC1 = s1; SRC2USE = u2; SRC2 = s2; FLUSH = fl;
   endtask

   task automatic idle();
      drive(0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
   endtask

   task automatic push(input int c, input logic [4:0] r);
      ret_t t;
      t.c = c;
      t.r = r;
      exp_q.push_back(t);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      idle();
      tick();
      tick();
      RESET = 1'b0;
      #1;
      checks++;
      if (BUSY !== 32'h0) begin
         errors++; $display("FAIL reset_busy: got %h required 0", BUSY);
      end
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b required 0", STALL);
      end
      checks++;
      if (STALLCNT !== 16'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d required 0", STALLCNT);
      end
      checks++;
      if (RETIRE_VLD !== 1'b0 || RETIRE_REG !== 5'd0) begin
         errors++;
         $display("FAIL reset_retire: got %b/%0d required 0/0",
                  RETIRE_VLD, RETIRE_REG);
      end
   endtask

   task automatic test_raw_stall();
      drive(1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0, 0);
      #1;
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL raw_issue: STALL got %b required 0", STALL);
      end
      push(cyc + 2, 5'd5);
      tick();
      drive(1, 1, 5'd9, 0, 1, 5'd5, 0, 5'd0, 0);
      #1;
      checks++;
      if (STALL !== 1'b1 || BUSY[5] !== 1'b1) begin
         errors++;
         $display("FAIL raw_c1: STALL/BUSY5 got %b/%b required 1/1", STALL, BUSY[5]);
      end
      tick();
      #1;
      checks++;
      if (STALL !== 1'b1 || FWD1 !== 1'b0) begin
         errors++;
         $display("FAIL raw_c2: STALL/FWD1 got %b/%b required 1/0", STALL, FWD1);
      end
      checks++;
      if (RETIRE_VLD !== 1'b1 || RETIRE_REG !== 5'd5) begin
         errors++;
         $display("FAIL raw_retire: got %b/%0d required 1/5", RETIRE_VLD, RETIRE_REG);
      end
      tick();
      #1;
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL raw_c3: STALL got %b required 0", STALL);
      end
      checks++;
      if (STALLCNT !== 16'd2) begin
         errors++; $display("FAIL raw_cnt: got %0d required 2", STALLCNT);
      end
      push(cyc + 2, 5'd9);
      tick();
      idle();
      tick();
      #1;
      checks++;
      if (BUSY !== 32'h200) begin
         errors++; $display("FAIL raw_busy9: got %h required 00000200", BUSY);
      end
      tick();
      #1;
      checks++;
      if (BUSY !== 32'h0) begin
         errors++; $display("FAIL raw_drain: got %h required 0", BUSY);
      end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 5'd1, 0, 0, 5'd0, 0, 5'd0, 0);
      push(cyc + 2, 5'd1);
      tick();
      drive(1, 1, 5'd2, 0, 0, 5'd1, 0, 5'd0, 0);
      #1;
      checks++;
      if (STALL !== 1'b0) begin
         errors++; $display("FAIL b2b_unused_src: STALL got %b required 0", STALL);
      end
      push(cyc + 2, 5'd2);
      tick();
      drive(1, 1, 5'd3, 0, 0, 5'd0, 1, 5'd30, 0);
      #1;
      checks++;
      if (STALL !== 1'b0 || BUSY !== 32'h6) begin
         errors++;
         $display("FAIL b2b_c2: STALL/BUSY got %b/%h required 0/00000006", STALL, BUSY);
      end
      push(cyc + 2, 5'd3);
      tick();
      idle();
      #1;
      checks++;
      if (BUSY !== 32'hC) begin
         errors++; $display("FAIL b2b_c3: BUSY got %h required 0000000c", BUSY);
      end
      tick();
      tick();
      #1;
      checks++;
      if (BUSY !== 32'h0) begin
         errors++; $display("FAIL b2b_drain: BUSY got %h required 0", BUSY);
      end
   endtask

   task automatic test_flush();
      drive(1, 1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0);
      push(cyc + 2, 5'd3);
      tick();
      drive(1, 1, 5'd4, 0, 0, 5'd0, 0, 5'd0, 0);
      tick();
      drive(1, 1, 5'd6, 0, 1, 5'd4, 0, 5'd0, 1);
      #1;
      checks++;
      if (STALL !== 1'b0 || BUSY !== 32'h18) begin
         errors++;
         $display("FAIL flush_cycle: STALL/BUSY got %b/%h required 0/00000018",
                  STALL, BUSY);
      end
      tick();
      idle();
      #1;
      checks++;
      if (BUSY !== 32'h0 || RETIRE_VLD !== 1'b0) begin
         errors++;
         $display("FAIL flush_after1: BUSY/RV got %h/%b required 0/0", BUSY, RETIRE_VLD);
      end
      checks++;
      if (STALLCNT !== 16'd2) begin
         errors++; $display("FAIL flush_cnt: got %0d required 2", STALLCNT);
      end
      tick();
      #1;
      checks++;
      if (RETIRE_VLD !== 1'b0) begin
         errors++; $display("FAIL flush_after2: RV got %b required 0", RETIRE_VLD);
      end
      tick();
   endtask

   task automatic test_dup_zero();
      drive(1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 0);
      push(cyc + 2, 5'd7);
      tick();
      push(cyc + 2, 5'd7);
      tick();
      drive(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7, 0);
      #1;
      checks++;
      if (STALL !== 1'b1 || BUSY[7] !== 1'b1) begin
         errors++;
         $display("FAIL dup_c1: STALL/BUSY7 got %b/%b required 1/1", STALL, BUSY[7]);
      end
      tick();
      #1;
      checks++;
      if (STALL !== 1'b1 || BUSY[7] !== 1'b1) begin
         errors++;
         $display("FAIL dup_c2: STALL/BUSY7 got %b/%b required 1/1", STALL, BUSY[7]);
      end
      tick();
      #1;
      checks++;
      if (STALL !== 1'b0 || BUSY[7] !== 1'b0) begin
         errors++;
         $display("FAIL dup_c3: STALL/BUSY7 got %b/%b required 0/0", STALL, BUSY[7]);
      end
      checks++;
      if (STALLCNT !== 16'd4) begin
         errors++; $display("FAIL dup_cnt: got %0d required 4", STALLCNT);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 5'(10 + i), 0, 1, 5'(10 + i), 1, 5'(10 + i), 0);
         #1;
         checks++;
         if (STALL !== 1'b0 || BUSY !== 32'h0) begin
            errors++;
            $display("FAIL zero_we_%0d: STALL/BUSY got %b/%h required 0/0",
                     i, STALL, BUSY);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_sat();
      int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
      RESET = 1'b1;
      idle();
      tick();
      RESET = 1'b0;
      #1;
      checks++;
      if (STALLCNT2 !== 2'd0) begin
         errors++; $display("FAIL sat_reset: got %0d required 0", STALLCNT2);
      end
      drive(1, 1, 5'd20, 0, 0, 5'd0, 0, 5'd0, 0);
      push(cyc + 2, 5'd20);
      tick();
      drive(1, 0, 5'd0, 0, 1, 5'd20, 0, 5'd0, 0);
      #1;
      checks++;
      if (STALL2 !== 1'b1) begin
         errors++; $display("FAIL sat_stall: got %b required 1", STALL2);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (STALLCNT2 !== 2'(sat_exp[i])) begin
            errors++;
            $display("FAIL sat_cnt_%0d: got %0d required %0d", i, STALLCNT2, sat_exp[i]);
         end
      end
      checks++;
      if (STALL2 !== 1'b1) begin
         errors++; $display("FAIL sat_midstall: got %b required 1", STALL2);
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      #1;
      checks++;
      if (STALLCNT2 !== 2'd0 || STALL2 !== 1'b0 || BUSY2 !== 32'h0) begin
         errors++;
         $display("FAIL sat_rst: cnt/stall/busy got %0d/%b/%h required 0/0/0",
                  STALLCNT2, STALL2, BUSY2);
      end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_raw_stall();
      test_back_to_back();
      test_flush();
      test_dup_zero();
      test_sat();
      tick();
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL retire_drain: %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
